// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and elaboration helpers for the reset sequencer.
//   state_e    : sequencer FSM states
//   max3       : largest of three integers (sizes the shared counter)
//   cnt_width  : bits needed to hold 0..max_val inclusive
//   ch_width   : bits for a channel index (minimum 1)
//   params_ok  : legality check for the sequencer parameter set
// ---------------------------------------------------------------------------
package rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD     = 2'd0,
      WAIT_RDY = 2'd1,
      GAP      = 2'd2,
      DONE     = 2'd3
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit params_ok(input int num_ch, input int hold,
                                    input int stagger, input int timeout);
      return (num_ch >= 1) && (num_ch <= 32) && (hold >= 1) &&
             (stagger >= 1) && (timeout >= 0);
   endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// ---------------------------------------------------------------------------
// bit_sync_2ff
// Two-flop synchroniser for a single asynchronous level into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets low
//   d     : asynchronous input level
//   q     : synchronised level, two clk edges behind d
// ---------------------------------------------------------------------------
module bit_sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
// Power-on / reset sequencer. Synchronises the board reset, holds all
// channels for HOLD_CYCLES, then releases channels one at a time, each
// waiting for its ready/lock (with optional timeout) and separated by
// STAGGER_CYCLES. Lock loss re-sequences from the lowest failing channel;
// ext_rst_req re-sequences everything from channel 0.
//   sys_clk, sys_rstn : clock, asynchronous active-low reset
//   ext_rst_req       : one-cycle software reset request
//   ch_ready_i        : per-channel ready/lock (asynchronous)
//   ch_rstn_o         : per-channel active-low resets (registered)
//   all_done          : every channel released and ready
//   cur_ch            : channel currently being sequenced
//   timeout_err       : sticky per-channel ready timeout
//   lock_lost         : sticky, a confirmed channel dropped ready
//   dbg_state         : current FSM state
// Handshake: none; ch_ready_i is a level, ext_rst_req a single-cycle strobe
// honoured on any edge once the internal reset synchroniser has released.
// ---------------------------------------------------------------------------
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int HOLD_CYCLES    = 65535,
   parameter int STAGGER_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                            sys_clk,
   input  logic                            sys_rstn,
   input  logic                            ext_rst_req,
   input  logic [NUM_CH-1:0]               ch_ready_i,
   output logic [NUM_CH-1:0]               ch_rstn_o,
   output logic                            all_done,
   output logic [ch_width(NUM_CH)-1:0]     cur_ch,
   output logic [NUM_CH-1:0]               timeout_err,
   output logic                            lock_lost,
   output logic [1:0]                      dbg_state
);

   localparam int CH_W    = ch_width(NUM_CH);
   localparam int CNT_TOP = max3(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES);
   localparam int CNT_W   = cnt_width(CNT_TOP);

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_TOP);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

   if (!params_ok(NUM_CH, HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES)) begin : g_param_err
      $error("rst_sequencer: illegal parameter set");
   end

   // Reset release synchroniser: assert asynchronously, release after 2 edges.
   (* ASYNC_REG = "TRUE" *) logic rst_meta_q;
   (* ASYNC_REG = "TRUE" *) logic rst_sync_q;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   logic [NUM_CH-1:0] ready_s;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_rdy_sync
      bit_sync_2ff u_sync (
         .clk   (sys_clk),
         .rst_n (sys_rstn),
         .d     (ch_ready_i[k]),
         .q     (ready_s[k])
      );
   end

   state_e            state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [NUM_CH-1:0] ch_rstn_q, ch_rstn_d;
   logic              all_done_q, all_done_d;
   logic [CH_W-1:0]   cur_ch_q,  cur_ch_d;
   logic [NUM_CH-1:0] to_err_q,  to_err_d;
   logic              lost_q,    lost_d;
   // conf: channel has shown ready since its release (eligible for lock loss)
   // ign : channel timed out; its ready is ignored until a restart from 0
   logic [NUM_CH-1:0] conf_q,    conf_d;
   logic [NUM_CH-1:0] ign_q,     ign_d;

   logic [NUM_CH-1:0] lost_vec;
   logic              lost_any;
   logic [CH_W-1:0]   lost_idx;
   logic [CNT_W-1:0]  cnt_inc;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         ch_rstn_q  <= '0;
         all_done_q <= 1'b0;
         cur_ch_q   <= '0;
         to_err_q   <= '0;
         lost_q     <= 1'b0;
         conf_q     <= '0;
         ign_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_rstn_q  <= ch_rstn_d;
         all_done_q <= all_done_d;
         cur_ch_q   <= cur_ch_d;
         to_err_q   <= to_err_d;
         lost_q     <= lost_d;
         conf_q     <= conf_d;
         ign_q      <= ign_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ch_rstn_d  = ch_rstn_q;
      all_done_d = all_done_q;
      cur_ch_d   = cur_ch_q;
      to_err_d   = to_err_q;
      lost_d     = lost_q;
      conf_d     = conf_q;
      ign_d      = ign_q;

      lost_vec = conf_q & ~ign_q & ~ready_s;
      lost_any = |lost_vec;
      lost_idx = '0;
      // Descending scan so the lowest failing channel wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (lost_vec[k]) lost_idx = CH_W'(k);
      end
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      if (rst_sync_q) begin
         if (ext_rst_req) begin
            state_d    = HOLD;
            cnt_d      = '0;
            ch_rstn_d  = '0;
            all_done_d = 1'b0;
            cur_ch_d   = '0;
            to_err_d   = '0;
            lost_d     = 1'b0;
            conf_d     = '0;
            ign_d      = '0;
         end else if (state_q != HOLD && lost_any) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (k >= int'(lost_idx)) begin
                  ch_rstn_d[k] = 1'b0;
                  conf_d[k]    = 1'b0;
               end
            end
            if (lost_idx == '0) ign_d = '0;
            state_d    = HOLD;
            cnt_d      = '0;
            all_done_d = 1'b0;
            cur_ch_d   = lost_idx;
            lost_d     = 1'b1;
         end else begin
            case (state_q)
               HOLD: begin
                  if (cnt_q == HOLD_LAST) begin
                     ch_rstn_d[cur_ch_q] = 1'b1;
                     state_d = WAIT_RDY;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
               WAIT_RDY: begin
                  if (ready_s[cur_ch_q] || (TO_EN && cnt_q == TO_LAST)) begin
                     if (ready_s[cur_ch_q]) begin
                        conf_d[cur_ch_q] = 1'b1;
                     end else begin
                        to_err_d[cur_ch_q] = 1'b1;
                        ign_d[cur_ch_q]    = 1'b1;
                     end
                     cnt_d = '0;
                     if (cur_ch_q == LAST_CH) begin
                        state_d    = DONE;
                        all_done_d = 1'b1;
                     end else begin
                        state_d = GAP;
                     end
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
               GAP: begin
                  if (cnt_q == GAP_LAST) begin
                     cur_ch_d = cur_ch_q + CH_W'(1);
                     ch_rstn_d[cur_ch_q + CH_W'(1)] = 1'b1;
                     state_d = WAIT_RDY;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ch_rstn_o   = ch_rstn_q;
   assign all_done    = all_done_q;
   assign cur_ch      = cur_ch_q;
   assign timeout_err = to_err_q;
   assign lock_lost   = lost_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
// Directed scenario sequence with randomised timing points. The expected
// outputs at every edge come from an event-time model: each output bit is
// 1 from a known edge number onward, with those edge numbers derived from
// the sequencer's timing rules (hold, stagger, timeout, restart latency).
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

   localparam int NUM_CH  = 2;
   localparam int HOLD    = 8;
   localparam int STAGGER = 4;
   localparam int TIMEOUT = 20;
   localparam int NEVER   = 1 << 30;

   logic       sys_clk     = 1'b0;
   logic       sys_rstn    = 1'b0;
   logic       ext_rst_req = 1'b0;
   logic [1:0] ch_ready_i  = 2'b11;
   logic [1:0] ch_rstn_o;
   logic       all_done;
   logic [0:0] cur_ch;
   logic [1:0] timeout_err;
   logic       lock_lost;
   logic [1:0] dbg_state;

   int tests  = 0;
   int fails  = 0;
   int edge_n = 0;

   // Event-time model: edge from which each output bit reads 1.
   int rel0_e, rel1_e, cur1_e, done_e, to0_e, to1_e, ll_e;

   logic [6:0] exp_q[$];

   rst_sequencer #(
      .NUM_CH         (NUM_CH),
      .HOLD_CYCLES    (HOLD),
      .STAGGER_CYCLES (STAGGER),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rstn    (sys_rstn),
      .ext_rst_req (ext_rst_req),
      .ch_ready_i  (ch_ready_i),
      .ch_rstn_o   (ch_rstn_o),
      .all_done    (all_done),
      .cur_ch      (cur_ch),
      .timeout_err (timeout_err),
      .lock_lost   (lock_lost),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- model ----------------
   task automatic set_model(input int r0, input int r1, input int c1,
                            input int dn, input int t0, input int t1,
                            input int ll);
      rel0_e = r0; rel1_e = r1; cur1_e = c1; done_e = dn;
      to0_e  = t0; to1_e  = t1; ll_e   = ll;
   endtask

   function automatic logic [6:0] model_out(input int n);
      return {n >= rel1_e, n >= rel0_e, n >= done_e, n >= cur1_e,
              n >= to1_e,  n >= to0_e,  n >= ll_e};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check_vec(input string tag, input logic [6:0] expv);
      logic [6:0] act;
      logic [6:0] e;
      exp_q.push_back(expv);
      e   = exp_q.pop_front();
      act = {ch_rstn_o, all_done, cur_ch, timeout_err, lock_lost};
      tests++;
      assert (act === e) else begin
         fails++;
         $error("FAIL %s edge=%0d observed={rstn,done,cur,to,ll}=%b expected=%b",
                tag, edge_n, act, e);
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input string tag, input int target);
      while (edge_n < target) begin
         tick();
         check_vec(tag, model_out(edge_n));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d, g, f, x, r;

      // Power-on, both ready tied high.
      sys_rstn   = 1'b0;
      ch_ready_i = 2'b11;
      #3;
      check_vec("por_reset", 7'b0);
      repeat (3) @(posedge sys_clk);
      #1;
      check_vec("por_reset_held", 7'b0);
      sys_rstn = 1'b1;
      edge_n   = 0;
      set_model(HOLD + 2, HOLD + 7, HOLD + 7, HOLD + 8, NEVER, NEVER, NEVER);
      run_to("power_on", 20);

      // Lock loss on channel 1 while DONE.
      d = int'($urandom_range(0, 4));
      run_to("done_idle", edge_n + d);
      g = edge_n;
      ch_ready_i[1] = 1'b0;
      f = g + 3;
      run_to("drop1_pre", f - 1);
      set_model(rel0_e, f + HOLD, cur1_e, f + HOLD + 1, NEVER, NEVER, f);
      run_to("drop1_loss", f);
      ch_ready_i[1] = 1'b1;
      run_to("drop1_rerelease", f + 12);

      // Both channels lose lock on the same edge: restart from channel 0.
      d = int'($urandom_range(0, 4));
      run_to("done_idle2", edge_n + d);
      g = edge_n;
      ch_ready_i = 2'b00;
      f = g + 3;
      run_to("drop_both_pre", f - 1);
      set_model(f + HOLD, f + HOLD + 5, f + HOLD + 5, f + HOLD + 6,
                NEVER, NEVER, ll_e);
      run_to("drop_both_loss", f);
      ch_ready_i = 2'b11;
      run_to("drop_both_reseq", f + 16);

      // Asynchronous reset between edges while DONE.
      #($urandom_range(1, 7));
      sys_rstn = 1'b0;
      #1;
      check_vec("async_reset", 7'b0);
      repeat (2) @(posedge sys_clk);
      #1;
      check_vec("async_reset_held", 7'b0);
      sys_rstn = 1'b1;
      edge_n   = 0;
      set_model(HOLD + 2, HOLD + 7, HOLD + 7, HOLD + 8, NEVER, NEVER, NEVER);
      run_to("restart", 20);

      // Channel 0 never ready: timeout, then continue to channel 1.
      sys_rstn   = 1'b0;
      ch_ready_i = 2'b10;
      #1;
      check_vec("reset_timeout", 7'b0);
      @(posedge sys_clk);
      #1;
      sys_rstn = 1'b1;
      edge_n   = 0;
      set_model(HOLD + 2, HOLD + 2 + TIMEOUT + STAGGER, HOLD + 2 + TIMEOUT + STAGGER,
                HOLD + 3 + TIMEOUT + STAGGER, HOLD + 2 + TIMEOUT, NEVER, NEVER);
      run_to("timeout", 36);

      // Software reset from DONE clears timeout_err and restarts.
      ch_ready_i = 2'b11;
      x = 36 + int'($urandom_range(3, 6));
      run_to("timeout_idle", x - 1);
      ext_rst_req = 1'b1;
      set_model(x + HOLD, x + HOLD + 5, x + HOLD + 5, x + HOLD + 6,
                NEVER, NEVER, NEVER);
      run_to("ext_done", x);
      ext_rst_req = 1'b0;

      // Software reset in GAP coinciding with a channel 0 lock loss.
      r = int'($urandom_range(0, 3));
      g = x + 7 + r;
      run_to("ext_seq", g);
      ch_ready_i[0] = 1'b0;
      f = g + 3;
      run_to("gap_pre", f - 1);
      ext_rst_req = 1'b1;
      set_model(f + HOLD, f + HOLD + 5, f + HOLD + 5, f + HOLD + 6,
                NEVER, NEVER, NEVER);
      run_to("ext_vs_loss", f);
      ext_rst_req   = 1'b0;
      ch_ready_i[0] = 1'b1;
      run_to("ext_rerelease", f + 16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
